// File: rtl/dram_pkg.sv
// ============================================================================
// Module : dram_pkg
// Brief  : Shared DRAM access-state encoding and beat/width helper functions.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dram_pkg;

  // Access-state encoding shared with the DRAM access controller
  localparam logic [2:0] ST_RESET   = 3'b000;
  localparam logic [2:0] ST_PARAMS  = 3'b001;
  localparam logic [2:0] ST_WEIGHTS = 3'b010;
  localparam logic [2:0] ST_SIGNALS = 3'b011;
  localparam logic [2:0] ST_INPUTS  = 3'b100;
  localparam logic [2:0] ST_FILLED  = 3'b101;

  function automatic int beats_for(input int width, input int beat_w);
    return (width + beat_w - 1) / beat_w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic is_active(input logic [2:0] st);
    return (st == ST_PARAMS) || (st == ST_WEIGHTS) ||
           (st == ST_SIGNALS) || (st == ST_INPUTS);
  endfunction

  // Entry widths for the default array geometry
  localparam int DEF_WEIGHT_ENTRY_W = 8 * 16;
  localparam int DEF_INPUT_ENTRY_W  = 8 * 16;
  localparam int DEF_SIGNAL_ENTRY_W = 100;
  localparam int DEF_PARAM_ENTRY_W  = 50;

endpackage : dram_pkg

`default_nettype wire

// File: rtl/beat_assembler.sv
// ============================================================================
// Module : beat_assembler
// Brief  : Little-endian beat collector with a per-entry beat counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module beat_assembler #(
  parameter int W         = 32,
  parameter int MAX_BEATS = 4,
  parameter int CNT_W     = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [W-1:0]           beat_i,
  input  logic                   valid_i,
  input  logic                   clear_i,
  input  logic [CNT_W-1:0]       beats_needed_i,
  output logic [W*MAX_BEATS-1:0] word_o,
  output logic                   done_o
);

  logic [W*MAX_BEATS-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [W*MAX_BEATS-1:0] base;
  logic [W*MAX_BEATS-1:0] merged;
  logic [CNT_W-1:0]       idx;

  // A clear and a beat in the same cycle start a fresh entry with that beat
  always_comb begin
    base   = clear_i ? '0 : acc_q;
    idx    = clear_i ? '0 : cnt_q;
    merged = base;
    for (int b = 0; b < MAX_BEATS; b++) begin
      if (valid_i && (idx == CNT_W'(b))) begin
        merged[b*W +: W] = beat_i;
      end
    end
    done_o = valid_i && (idx == (beats_needed_i - CNT_W'(1)));
    acc_d  = base;
    cnt_d  = idx;
    if (valid_i) begin
      if (done_o) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = merged;
        cnt_d = idx + CNT_W'(1);
      end
    end
    word_o = merged;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule : beat_assembler

`default_nettype wire

// File: rtl/dram_word_packer.sv
// ============================================================================
// Module : dram_word_packer
// Brief  : Packs DRAM read beats into parameter/weight/signal/input entries.
//          Optional byte reversal of each beat: DRAM_PACKER_BYTE_SWAP_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_word_packer
  import dram_pkg::*;
#(
  parameter int DATA_IN_DRAM_WIDTH       = 32,
  parameter int PARAMETERS_WIDTH         = 50,
  parameter int ROM_SIG_WIDTH            = 100,
  parameter int N_ROWS_ARRAY             = 16,
  parameter int I_WIDTH                  = 8,
  parameter int F_WIDTH                  = 8,
  parameter int SIG_ADDRS_WIDTH          = 16,
  parameter int INPUT_FEATURE_ADDR_WIDTH = 16
) (
  input  logic                                 clk_i,
  input  logic                                 general_rst_i,
  input  logic [2:0]                           dram_access_state_i,
  input  logic [DATA_IN_DRAM_WIDTH-1:0]        dram_rd_data_i,
  input  logic                                 dram_rd_valid_i,
  input  logic [SIG_ADDRS_WIDTH-1:0]           weight_wr_address_i,
  input  logic [SIG_ADDRS_WIDTH-1:0]           signal_wr_address_i,
  input  logic [INPUT_FEATURE_ADDR_WIDTH-1:0]  input_wr_address_i,
  output logic [PARAMETERS_WIDTH-1:0]          params_o,
  output logic                                 params_valid_o,
  output logic                                 weight_we_o,
  output logic                                 signal_we_o,
  output logic                                 input_we_o,
  output logic [max2(SIG_ADDRS_WIDTH, INPUT_FEATURE_ADDR_WIDTH)-1:0] wr_addr_o,
  output logic [max2(max2(I_WIDTH*N_ROWS_ARRAY, F_WIDTH*N_ROWS_ARRAY),
                     ROM_SIG_WIDTH)-1:0]       wr_data_o
);

  localparam int W           = DATA_IN_DRAM_WIDTH;
  localparam int WEIGHT_W    = F_WIDTH * N_ROWS_ARRAY;
  localparam int INPUT_W     = I_WIDTH * N_ROWS_ARRAY;
  localparam int BEATS_PARAM = beats_for(PARAMETERS_WIDTH, W);
  localparam int BEATS_WGT   = beats_for(WEIGHT_W, W);
  localparam int BEATS_SIG   = beats_for(ROM_SIG_WIDTH, W);
  localparam int BEATS_INP   = beats_for(INPUT_W, W);
  localparam int MAX_BEATS   = max2(max2(BEATS_PARAM, BEATS_WGT), max2(BEATS_SIG, BEATS_INP));
  localparam int ASM_W       = W * MAX_BEATS;
  localparam int CNT_W       = $clog2(MAX_BEATS) + 1;
  localparam int ADDR_W      = max2(SIG_ADDRS_WIDTH, INPUT_FEATURE_ADDR_WIDTH);
  localparam int DATA_W      = max2(max2(INPUT_W, WEIGHT_W), ROM_SIG_WIDTH);

  logic [W-1:0] beat_in;

`ifdef DRAM_PACKER_BYTE_SWAP_EN
  for (genvar i = 0; i < W / 8; i++) begin : g_swap
    assign beat_in[8*i +: 8] = dram_rd_data_i[W-8-8*i +: 8];
  end
`else
  assign beat_in = dram_rd_data_i;
`endif

  logic [2:0]            state_prev_q, state_prev_d;
  logic                  active;
  logic                  asm_clear;
  logic                  asm_valid;
  logic                  asm_done;
  logic [CNT_W-1:0]      beats_needed;
  logic [ASM_W-1:0]      asm_word;
  logic [DATA_W-1:0]     entry;

  logic [PARAMETERS_WIDTH-1:0] params_q, params_d;
  logic                        params_valid_q, params_valid_d;
  logic                        weight_we_q, weight_we_d;
  logic                        signal_we_q, signal_we_d;
  logic                        input_we_q, input_we_d;
  logic [ADDR_W-1:0]           wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]           wr_data_q, wr_data_d;

  // Any state change drops a partial entry; idle states keep it cleared
  always_comb begin
    state_prev_d = dram_access_state_i;
    active       = is_active(dram_access_state_i);
    asm_clear    = (dram_access_state_i != state_prev_q) || !active;
    asm_valid    = dram_rd_valid_i && active;
    case (dram_access_state_i)
      ST_PARAMS:  beats_needed = CNT_W'(BEATS_PARAM);
      ST_WEIGHTS: beats_needed = CNT_W'(BEATS_WGT);
      ST_SIGNALS: beats_needed = CNT_W'(BEATS_SIG);
      ST_INPUTS:  beats_needed = CNT_W'(BEATS_INP);
      default:    beats_needed = CNT_W'(MAX_BEATS);
    endcase
  end

  beat_assembler #(
    .W         (W),
    .MAX_BEATS (MAX_BEATS),
    .CNT_W     (CNT_W)
  ) u_asm (
    .clk_i          (clk_i),
    .rst_i          (general_rst_i),
    .beat_i         (beat_in),
    .valid_i        (asm_valid),
    .clear_i        (asm_clear),
    .beats_needed_i (beats_needed),
    .word_o         (asm_word),
    .done_o         (asm_done)
  );

  always_comb begin
    entry = '0;
    case (dram_access_state_i)
      ST_WEIGHTS: entry[WEIGHT_W-1:0]      = asm_word[WEIGHT_W-1:0];
      ST_SIGNALS: entry[ROM_SIG_WIDTH-1:0] = asm_word[ROM_SIG_WIDTH-1:0];
      ST_INPUTS:  entry[INPUT_W-1:0]       = asm_word[INPUT_W-1:0];
      default:    entry = '0;
    endcase

    params_d       = params_q;
    params_valid_d = params_valid_q;
    weight_we_d    = 1'b0;
    signal_we_d    = 1'b0;
    input_we_d     = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;

    if (dram_access_state_i == ST_RESET) begin
      params_d       = '0;
      params_valid_d = 1'b0;
    end

    if (asm_done) begin
      case (dram_access_state_i)
        ST_PARAMS: begin
          params_d       = asm_word[PARAMETERS_WIDTH-1:0];
          params_valid_d = 1'b1;
        end
        ST_WEIGHTS: begin
          weight_we_d = 1'b1;
          wr_addr_d   = ADDR_W'(weight_wr_address_i);
          wr_data_d   = entry;
        end
        ST_SIGNALS: begin
          signal_we_d = 1'b1;
          wr_addr_d   = ADDR_W'(signal_wr_address_i);
          wr_data_d   = entry;
        end
        ST_INPUTS: begin
          input_we_d = 1'b1;
          wr_addr_d  = ADDR_W'(input_wr_address_i);
          wr_data_d  = entry;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge general_rst_i) begin
    if (general_rst_i) begin
      state_prev_q   <= ST_RESET;
      params_q       <= '0;
      params_valid_q <= 1'b0;
      weight_we_q    <= 1'b0;
      signal_we_q    <= 1'b0;
      input_we_q     <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
    end else begin
      state_prev_q   <= state_prev_d;
      params_q       <= params_d;
      params_valid_q <= params_valid_d;
      weight_we_q    <= weight_we_d;
      signal_we_q    <= signal_we_d;
      input_we_q     <= input_we_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
    end
  end

  assign params_o       = params_q;
  assign params_valid_o = params_valid_q;
  assign weight_we_o    = weight_we_q;
  assign signal_we_o    = signal_we_q;
  assign input_we_o     = input_we_q;
  assign wr_addr_o      = wr_addr_q;
  assign wr_data_o      = wr_data_q;

endmodule : dram_word_packer

`default_nettype wire

// File: tb/tb_dram_word_packer.sv
// ============================================================================
// Module : tb_dram_word_packer
// Brief  : Directed self-checking bench for dram_word_packer (default build).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_word_packer;

  logic         clk;
  logic         rst;
  logic [2:0]   state;
  logic [31:0]  rd_data;
  logic         rd_valid;
  logic [15:0]  weight_addr;
  logic [15:0]  signal_addr;
  logic [15:0]  input_addr;
  logic [49:0]  params;
  logic         params_valid;
  logic         weight_we;
  logic         signal_we;
  logic         input_we;
  logic [15:0]  wr_addr;
  logic [127:0] wr_data;

  int compared = 0;
  int mismatched = 0;

  dram_word_packer dut (
    .clk_i               (clk),
    .general_rst_i       (rst),
    .dram_access_state_i (state),
    .dram_rd_data_i      (rd_data),
    .dram_rd_valid_i     (rd_valid),
    .weight_wr_address_i (weight_addr),
    .signal_wr_address_i (signal_addr),
    .input_wr_address_i  (input_addr),
    .params_o            (params),
    .params_valid_o      (params_valid),
    .weight_we_o         (weight_we),
    .signal_we_o         (signal_we),
    .input_we_o          (input_we),
    .wr_addr_o           (wr_addr),
    .wr_data_o           (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_we(input string tag, input logic w, input logic s, input logic i);
    check({tag, "_weight_we"}, 128'(weight_we), 128'(w));
    check({tag, "_signal_we"}, 128'(signal_we), 128'(s));
    check({tag, "_input_we"},  128'(input_we),  128'(i));
  endtask

  logic [31:0]  wbeats [4];
  logic [127:0] exp_entry;
  int           beat_i;
  int           strobes;

  initial begin
    rst = 1'b1; state = 3'b000; rd_data = '0; rd_valid = 1'b0;
    weight_addr = '0; signal_addr = '0; input_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_params", 128'(params), 128'h0);
    check("rst_params_valid", 128'(params_valid), 128'h0);
    check_we("rst", 1'b0, 1'b0, 1'b0);
    check("rst_wr_addr", 128'(wr_addr), 128'h0);
    check("rst_wr_data", wr_data, 128'h0);
    rst = 1'b0;
    tick();

    // Parameters: two beats, 50-bit truncation
    state = 3'b001; rd_valid = 1'b1; rd_data = 32'h1111_2222;
    tick();
    check("param_partial_valid", 128'(params_valid), 128'h0);
    rd_data = 32'h0003_3333;
    tick();
    check("param_value", 128'(params), 128'(50'h3_3333_1111_2222));
    check("param_valid", 128'(params_valid), 128'h1);
    rd_valid = 1'b0;
    tick();
    check("param_sticky", 128'(params_valid), 128'h1);

    // Weights: four beats at address 5
    wbeats[0] = 32'hA000_00A0; wbeats[1] = 32'hA111_11A1;
    wbeats[2] = 32'hA222_22A2; wbeats[3] = 32'hA333_33A3;
    state = 3'b010; weight_addr = 16'd5; signal_addr = 16'd77; input_addr = 16'd88;
    for (int b = 0; b < 4; b++) begin
      rd_valid = 1'b1; rd_data = wbeats[b];
      tick();
      check_we($sformatf("wgt_b%0d", b), (b == 3), 1'b0, 1'b0);
    end
    check("wgt_addr", 128'(wr_addr), 128'd5);
    check("wgt_data", wr_data, 128'hA33333A3_A22222A2_A11111A1_A00000A0);
    rd_valid = 1'b0; weight_addr = 16'd6;
    tick();
    check_we("wgt_after", 1'b0, 1'b0, 1'b0);
    check("wgt_data_hold", wr_data, 128'hA33333A3_A22222A2_A11111A1_A00000A0);
    check("wgt_addr_hold", 128'(wr_addr), 128'd5);

    // Signals: all-ones beats truncated to 100 bits
    state = 3'b011; signal_addr = 16'd9;
    for (int b = 0; b < 4; b++) begin
      rd_valid = 1'b1; rd_data = 32'hFFFF_FFFF;
      tick();
      check_we($sformatf("sig_b%0d", b), 1'b0, (b == 3), 1'b0);
    end
    check("sig_addr", 128'(wr_addr), 128'd9);
    check("sig_data", wr_data, 128'h0000000F_FFFFFFFF_FFFFFFFF_FFFFFFFF);

    // Inputs: partial entry abandoned by a trip through filled
    state = 3'b100; input_addr = 16'd7;
    rd_valid = 1'b1; rd_data = 32'hDEAD_0001;
    tick();
    rd_data = 32'hDEAD_0002;
    tick();
    check_we("inp_partial", 1'b0, 1'b0, 1'b0);
    state = 3'b101; rd_data = 32'hDEAD_0003;
    tick();
    check_we("inp_filled", 1'b0, 1'b0, 1'b0);
    state = 3'b100;
    for (int b = 0; b < 4; b++) begin
      rd_valid = 1'b1; rd_data = 32'h0000_1111 * (b + 1);
      tick();
      check_we($sformatf("inp_fresh_b%0d", b), 1'b0, 1'b0, (b == 3));
    end
    check("inp_data", wr_data, 128'h00004444_00003333_00002222_00001111);
    check("inp_addr", 128'(wr_addr), 128'd7);
    rd_valid = 1'b0;
    tick();
    check_we("inp_after", 1'b0, 1'b0, 1'b0);
    check("params_still_valid", 128'(params_valid), 128'h1);

    // Reset access state clears the parameter register
    state = 3'b000; rd_valid = 1'b1; rd_data = 32'h1234_5678;
    tick();
    check("rststate_params", 128'(params), 128'h0);
    check("rststate_params_valid", 128'(params_valid), 128'h0);
    check_we("rststate", 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-entry
    state = 3'b010; weight_addr = 16'd3;
    for (int b = 0; b < 3; b++) begin
      rd_valid = 1'b1; rd_data = 32'h5555_0000 + b;
      tick();
    end
    rd_data = 32'h5555_0003;
    #2 rst = 1'b1;
    #1;
    check("arst_wr_data", wr_data, 128'h0);
    check("arst_wr_addr", 128'(wr_addr), 128'h0);
    check_we("arst", 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0; rd_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_we($sformatf("post_rst_c%0d", c), 1'b0, 1'b0, 1'b0);
    end
    rd_valid = 1'b1; rd_data = 32'h5555_0004;
    tick();
    check_we("post_rst_beat", 1'b0, 1'b0, 1'b0);
    rd_valid = 1'b0;
    tick();

    // Inputs: 12 beats with valid toggling 1,0,1,...
    state = 3'b100; beat_i = 0; strobes = 0;
    tick();
    for (int c = 0; c < 24; c++) begin
      rd_valid = ((c % 2) == 0);
      if (rd_valid) begin
        rd_data    = 32'hC000_0000 + beat_i;
        input_addr = 16'(20 + beat_i / 4);
        beat_i++;
      end
      tick();
      if (weight_we || signal_we) begin
        check("stream_wrong_we", 128'({weight_we, signal_we}), 128'h0);
      end
      if (input_we) begin
        exp_entry = {32'hC000_0003 + 32'(4*strobes), 32'hC000_0002 + 32'(4*strobes),
                     32'hC000_0001 + 32'(4*strobes), 32'hC000_0000 + 32'(4*strobes)};
        check($sformatf("stream_addr_%0d", strobes), 128'(wr_addr), 128'(20 + strobes));
        check($sformatf("stream_data_%0d", strobes), wr_data, exp_entry);
        strobes++;
      end
    end
    check("stream_strobe_count", 128'(strobes), 128'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_dram_word_packer

`default_nettype wire

// File: doc/dram_word_packer.md
# dram_word_packer

Assembles the 32-bit word stream read from DRAM into full-width parameter, weight, signal and input-feature entries. Issues one BRAM write strobe per completed entry. Sits directly downstream of the DRAM access controller:
- consumes its 3-bit access state and its weight/signal/input write addresses;
- drives the on-chip parameter register and the weight, signal-ROM and input-feature BRAM write ports.

## Interface
Parameters:
- DATA_IN_DRAM_WIDTH, 32, width of one DRAM read beat
- PARAMETERS_WIDTH, 50, parameter entry width
- ROM_SIG_WIDTH, 100, signal entry width
- N_ROWS_ARRAY, 16, systolic array rows
- I_WIDTH, 8, input element width
- F_WIDTH, 8, filter element width
- SIG_ADDRS_WIDTH, 16, weight/signal BRAM address width
- INPUT_FEATURE_ADDR_WIDTH, 16, input BRAM address width

Ports:
- clk_i  in  1  clock, all logic on rising edge
- general_rst_i  in  1  reset, asynchronous, active-high
- dram_access_state_i  in  3  controller state: 000 reset, 001 parameters, 010 weights, 011 signals, 100 inputs, 101 filled
- dram_rd_data_i  in  DATA_IN_DRAM_WIDTH  DRAM read data
- dram_rd_valid_i  in  1  dram_rd_data_i carries a beat this cycle
- weight_wr_address_i  in  SIG_ADDRS_WIDTH  controller weight write address
- signal_wr_address_i  in  SIG_ADDRS_WIDTH  controller signal write address
- input_wr_address_i  in  INPUT_FEATURE_ADDR_WIDTH  controller input write address
- params_o  out  PARAMETERS_WIDTH  latched parameter entry
- params_valid_o  out  1  params_o holds a complete entry (sticky)
- weight_we_o  out  1  weight BRAM write strobe
- signal_we_o  out  1  signal BRAM write strobe
- input_we_o  out  1  input BRAM write strobe
- wr_addr_o  out  max(SIG_ADDRS_WIDTH, INPUT_FEATURE_ADDR_WIDTH)  write address, zero-extended
- wr_data_o  out  max(I_WIDTH·N_ROWS_ARRAY, F_WIDTH·N_ROWS_ARRAY, ROM_SIG_WIDTH)  entry data, zero-extended

## Operation
- Beats per entry, with W = DATA_IN_DRAM_WIDTH: BEATS_X = ceil(X_WIDTH / W). Defaults: param 2, weight 4, signal 4, input 4.
- Active states are parameters, weights, signals and inputs. In reset and filled, valid beats are ignored and the assembler stays cleared.
- In an active state, each cycle with dram_rd_valid_i=1 does two things:
  - shifts the beat into the assembler, little-endian (first beat → bits [W-1:0]);
  - increments beat_cnt.
- Entry completes on the beat where beat_cnt == BEATS_X-1:
  - entry is truncated to X_WIDTH, i.e. upper bits of the last beat are dropped;
  - beat_cnt returns to 0.
- On completion in parameters: params_o ← entry, params_valid_o ← 1.
- On completion in weights, signals or inputs:
  - wr_data_o ← entry, zero-extended;
  - wr_addr_o ← the matching controller address, sampled in the completing cycle;
  - the matching we strobe pulses high for exactly one cycle.
- State change with a partial entry: partial data is discarded, beat_cnt is cleared, and no strobe is issued. A beat arriving in the same cycle as the change belongs to the new state's first entry.
- Entering reset or filled clears beat_cnt and the assembler. params_o and params_valid_o are cleared only by general_rst_i or the reset state.
- At most one we strobe is high in any cycle.

## Timing
- Reset values: params_o 0, params_valid_o 0, all we 0, wr_addr_o 0, wr_data_o 0, beat_cnt 0.
- Reset is asynchronous. Assertion mid-entry drops the entry immediately; no strobe follows.
- Latency: strobe, wr_data_o and wr_addr_o are registered and appear one cycle after the completing beat's edge.
- wr_data_o and wr_addr_o hold until the next completion.
- Back-to-back: a continuous valid stream yields one strobe every BEATS_X cycles, with no bubbles.
- Gaps in dram_rd_valid_i stall assembly without loss.
- params_valid_o rises one cycle after the final parameter beat.

## Configuration
- Macro DRAM_PACKER_BYTE_SWAP_EN.
- Defined: each incoming beat is byte-reversed before shifting (bits [7:0] ↔ [W-1:W-8], and so on). This serves big-endian host images.
- Undefined: beats are used as received. The swap logic is absent, with zero area.

## Structure
- Shared package dram_pkg holds:
  - the 3-bit access-state encoding constants (shared with the controller);
  - the BEATS_X computation function;
  - the derived entry-width constants.
- One sub-module, beat_assembler, is natural. It is a parameterised shift-in register plus beat counter:
  - inputs: beat, valid, clear, beats_needed;
  - outputs: the assembled word and a done pulse.
- The top level holds the state decode, truncation, the output registers and the strobe steering.

## Test plan
- Parameters state, beats 0x11112222 then 0x00033333 → params_o = 50'h3_3333_1111_2222, params_valid_o=1 one cycle later.
- Weights state, addr 5, beats A0,A1,A2,A3 → weight_we_o single pulse; wr_addr_o=5; wr_data_o={A3,A2,A1,A0}.
- Signals state, beats 0xFFFFFFFF ×4 → wr_data_o = 100'hF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF (upper 28 bits of last beat dropped), signal_we_o pulse.
- Inputs state, 2 beats then state → filled → no input_we_o. Then state → inputs with 4 fresh beats → exactly one strobe, carrying only the fresh data.
- general_rst_i asserted after 3 weight beats, mid-cycle → all outputs 0 asynchronously; no strobe after release.
- Continuous 12-beat input stream with valid toggling 1,0,1… → exactly 3 input_we_o pulses; addresses follow the controller; no data loss.
